// File: rtl/tensor_core_pkg.sv
// Shared constants, opcode and state encodings for the tensor core controller slice.
package tensor_core_pkg;

    localparam int NUM_REGS = 18;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 8;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_LOAD    = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_READ    = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_TC_START = 3'd2,
        ST_TC_WAIT  = 3'd3,
        ST_COMMIT   = 3'd4,
        ST_READ     = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/tensor_core_stream_counter.sv
// Register-file index counter (0..NUM_REGS-1) shared by the LOAD and READ streams.
module tensor_core_stream_counter
    import tensor_core_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // Stepping past the last register folds back to zero so the index never leaves range.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (incr_i) begin
            count_d = (count_q == LAST_ADDR) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_ADDR);

endmodule

// File: rtl/tensor_core_controller.sv
// Command sequencer for the tensor core register file and compute engine.
// Optional compute watchdog and error_out port: define TENSOR_CORE_CONTROLLER_TIMEOUT_EN.
module tensor_core_controller
   import tensor_core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              cmd_valid_in,
   output logic              cmd_ready_out,
   input  logic [1:0]        cmd_opcode_in,
   input  logic              load_data_valid_in,
   output logic              load_data_ready_out,
   input  logic [DATA_W-1:0] load_data_in,
   output logic              rf_non_bulk_write_enable_out,
   output logic [ADDR_W-1:0] rf_non_bulk_write_register_address_out,
   output logic [DATA_W-1:0] rf_non_bulk_write_data_out,
   output logic              rf_bulk_write_enable_out,
   output logic [ADDR_W-1:0] rf_non_bulk_read_register_address_out,
   input  logic [DATA_W-1:0] rf_non_bulk_read_data_in,
   output logic              tc_start_out,
   input  logic              tc_done_in,
   output logic              result_valid_out,
   input  logic              result_ready_in,
   output logic [DATA_W-1:0] result_data_out,
`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
   output logic              error_out,
`endif
   output logic              busy_out
);

   ctrl_state_e       state_q;
   ctrl_state_e       state_d;
   logic              cmdAccept;
   logic              loadFire;
   logic              readFire;
   logic [ADDR_W-1:0] cntValue;
   logic              cntLast;

   assign cmdAccept = cmd_valid_in && (state_q == ST_IDLE);
   assign loadFire  = load_data_valid_in && (state_q == ST_LOAD);
   assign readFire  = result_ready_in && (state_q == ST_READ);

   tensor_core_stream_counter u_counter (
      .clock_i (clock_in),
      .reset_i (reset_in),
      .clear_i (cmdAccept),
      .incr_i  (loadFire || readFire),
      .count_o (cntValue),
      .last_o  (cntLast)
   );

`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [WDOG_W-1:0] wdog_q;
   logic [WDOG_W-1:0] wdog_d;
   logic              error_q;
   logic              error_d;
   logic              timeoutHit;

   assign timeoutHit = (state_q == ST_TC_WAIT) && !tc_done_in && (wdog_q == WDOG_LAST);

   // The watchdog only counts TC_WAIT cycles; a new COMPUTE clears any stale error.
   always_comb begin
      wdog_d  = (state_q == ST_TC_WAIT) ? wdog_q + 1'b1 : '0;
      error_d = error_q;
      if (cmdAccept && (cmd_opcode_in == OP_COMPUTE)) begin
         error_d = 1'b0;
      end else if (timeoutHit) begin
         error_d = 1'b1;
      end
   end

   // Watchdog and sticky error registers, cleared by synchronous reset.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         wdog_q  <= '0;
         error_q <= 1'b0;
      end else begin
         wdog_q  <= wdog_d;
         error_q <= error_d;
      end
   end

   assign error_out = error_q;
`endif

   // Next-state logic for the command sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               case (cmd_opcode_in)
                  OP_LOAD:    state_d = ST_LOAD;
                  OP_COMPUTE: state_d = ST_TC_START;
                  OP_READ:    state_d = ST_READ;
                  default:    state_d = ST_IDLE;
               endcase
            end
         end
         ST_LOAD: begin
            if (loadFire && cntLast) begin
               state_d = ST_IDLE;
            end
         end
         ST_TC_START: state_d = ST_TC_WAIT;
         ST_TC_WAIT: begin
            if (tc_done_in) begin
               state_d = ST_COMMIT;
            end
`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
            else if (timeoutHit) begin
               state_d = ST_IDLE;
            end
`endif
         end
         ST_COMMIT: state_d = ST_IDLE;
         ST_READ: begin
            if (readFire && cntLast) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with synchronous reset to IDLE.
   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Data paths are gated so idle outputs read as zero rather than echoing inputs.
   assign cmd_ready_out                          = (state_q == ST_IDLE);
   assign busy_out                               = (state_q != ST_IDLE);
   assign load_data_ready_out                    = (state_q == ST_LOAD);
   assign rf_non_bulk_write_enable_out           = loadFire;
   assign rf_non_bulk_write_register_address_out = cntValue;
   assign rf_non_bulk_write_data_out             = loadFire ? load_data_in : '0;
   assign rf_bulk_write_enable_out               = (state_q == ST_COMMIT);
   assign tc_start_out                           = (state_q == ST_TC_START);
   assign rf_non_bulk_read_register_address_out  = cntValue;
   assign result_valid_out                       = (state_q == ST_READ);
   assign result_data_out = (state_q == ST_READ) ? rf_non_bulk_read_data_in : '0;

endmodule

// File: tb/tb_tensor_core_controller.sv
// Randomized scoreboard bench for tensor_core_controller with a register-file and tensor-core stand-in.
// Exercises the watchdog and error_out when TENSOR_CORE_CONTROLLER_TIMEOUT_EN is defined.
module tb_tensor_core_controller;

   localparam int NREGS = 18;
   localparam int TO_CYCLES = 10;

   logic       clock_in = 1'b0;
   logic       reset_in = 1'b1;
   logic       cmd_valid_in = 1'b0;
   logic       cmd_ready_out;
   logic [1:0] cmd_opcode_in = 2'b00;
   logic       load_data_valid_in = 1'b0;
   logic       load_data_ready_out;
   logic [7:0] load_data_in = 8'h00;
   logic       nbWe;
   logic [4:0] nbWaddr;
   logic [7:0] nbWdata;
   logic       bulkWe;
   logic [4:0] rdAddr;
   logic [7:0] rdData;
   logic       tc_start_out;
   logic       tc_done_in = 1'b0;
   logic       result_valid_out;
   logic       result_ready_in = 1'b0;
   logic [7:0] result_data_out;
   logic       busy_out;
`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
   logic       error_out;
`endif

   tensor_core_controller #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .clock_in                               (clock_in),
      .reset_in                               (reset_in),
      .cmd_valid_in                           (cmd_valid_in),
      .cmd_ready_out                          (cmd_ready_out),
      .cmd_opcode_in                          (cmd_opcode_in),
      .load_data_valid_in                     (load_data_valid_in),
      .load_data_ready_out                    (load_data_ready_out),
      .load_data_in                           (load_data_in),
      .rf_non_bulk_write_enable_out           (nbWe),
      .rf_non_bulk_write_register_address_out (nbWaddr),
      .rf_non_bulk_write_data_out             (nbWdata),
      .rf_bulk_write_enable_out               (bulkWe),
      .rf_non_bulk_read_register_address_out  (rdAddr),
      .rf_non_bulk_read_data_in               (rdData),
      .tc_start_out                           (tc_start_out),
      .tc_done_in                             (tc_done_in),
      .result_valid_out                       (result_valid_out),
      .result_ready_in                        (result_ready_in),
      .result_data_out                        (result_data_out),
`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
      .error_out                              (error_out),
`endif
      .busy_out                               (busy_out)
   );

   always #5 clock_in = ~clock_in;

   int checks = 0;
   int errors = 0;
   int writeCount = 0;
   int bulkCount = 0;
   int startCount = 0;

   logic [7:0]  rfMem [NREGS];
   logic [7:0]  tcResult [NREGS];
   logic [7:0]  refMem [NREGS];
   logic [12:0] writeQ [$];
   logic [12:0] readQ [$];

   // Register file stand-in: single writes from LOAD, whole-array copy on commit.
   always @(posedge clock_in) begin
      if (nbWe && nbWaddr < 5'(NREGS)) rfMem[nbWaddr] <= nbWdata;
      if (bulkWe) begin
         for (int i = 0; i < NREGS; i++) rfMem[i] <= tcResult[i];
      end
   end
   assign rdData = (rdAddr < 5'(NREGS)) ? rfMem[rdAddr] : 8'h00;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or delivers a byte.
   always @(negedge clock_in) begin
      logic [12:0] exp;
      if (!reset_in) begin
         if (nbWe || bulkWe) checkOutput("we exclusive", {31'b0, nbWe & bulkWe}, 32'd0);
         if (bulkWe) bulkCount++;
         if (tc_start_out) startCount++;
         if (nbWe) begin
            writeCount++;
            if (writeQ.size() == 0) begin
               checkOutput("write expected", 32'd0, 32'd1);
            end else begin
               exp = writeQ.pop_front();
               checkOutput("write addr", {27'b0, nbWaddr}, {27'b0, exp[12:8]});
               checkOutput("write data", {24'b0, nbWdata}, {24'b0, exp[7:0]});
            end
         end
         if (result_valid_out && result_ready_in) begin
            if (readQ.size() == 0) begin
               checkOutput("read expected", 32'd0, 32'd1);
            end else begin
               exp = readQ.pop_front();
               checkOutput("read addr", {27'b0, rdAddr}, {27'b0, exp[12:8]});
               checkOutput("read data", {24'b0, result_data_out}, {24'b0, exp[7:0]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic issueCmd(input logic [1:0] op);
      int k = 0;
      cmd_valid_in  = 1'b1;
      cmd_opcode_in = op;
      @(negedge clock_in);
      while (!cmd_ready_out && k < 100) begin
         @(negedge clock_in);
         k++;
      end
      checkOutput("cmd accept", {31'b0, cmd_ready_out}, 32'd1);
      tick();
      cmd_valid_in  = 1'b0;
      cmd_opcode_in = 2'b00;
   endtask

   // mode 0: back-to-back 1..18, mode 1: valid every other cycle with -128/127, mode 2: random.
   task automatic doLoad(input int mode, input int count);
      int cycles = 0;
      int wStart = writeCount;
      logic [7:0] b;
      issueCmd(2'b01);
      for (int i = 0; i < count; i++) begin
         case (mode)
            0: b = 8'(i + 1);
            1: b = (i % 2 == 0) ? 8'h80 : 8'h7F;
            default: b = 8'($urandom);
         endcase
         writeQ.push_back({5'(i), b});
         refMem[i] = b;
         if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            load_data_valid_in = 1'b0;
            tick();
            cycles++;
         end
         load_data_valid_in = 1'b1;
         load_data_in = b;
         tick();
         cycles++;
      end
      load_data_valid_in = 1'b0;
      if (count == NREGS) begin
         if (mode == 0) checkOutput("load cycles", cycles, 32'd18);
         if (mode == 1) checkOutput("load cycles toggled", cycles, 32'd36);
         checkOutput("load done ready", {31'b0, cmd_ready_out}, 32'd1);
         checkOutput("load done busy", {31'b0, busy_out}, 32'd0);
      end
      checkOutput("load write count", writeCount - wStart, count);
      checkOutput("load queue drained", writeQ.size(), 32'd0);
   endtask

   // Completes a COMPUTE once it has been accepted and the DUT sits in TC_START.
   task automatic finishCompute(input int delay, input bit earlyDone, input int sStart, input int bStart);
      checkOutput("start pulse", {31'b0, tc_start_out}, 32'd1);
      tc_done_in = earlyDone;
      tick();
      tc_done_in = 1'b0;
      checkOutput("wait no bulk", {31'b0, bulkWe}, 32'd0);
      checkOutput("wait cmd held off", {31'b0, cmd_ready_out}, 32'd0);
      repeat (delay) tick();
      for (int i = 0; i < NREGS; i++) tcResult[i] = 8'($urandom);
      tc_done_in = 1'b1;
      tick();
      tc_done_in = 1'b0;
      checkOutput("commit bulk", {31'b0, bulkWe}, 32'd1);
      for (int i = 0; i < NREGS; i++) refMem[i] = tcResult[i];
      tick();
      checkOutput("commit one cycle", {31'b0, bulkWe}, 32'd0);
      checkOutput("compute idle", {31'b0, cmd_ready_out}, 32'd1);
      checkOutput("start count", startCount - sStart, 32'd1);
      checkOutput("bulk count", bulkCount - bStart, 32'd1);
   endtask

   task automatic doCompute(input int delay, input bit earlyDone);
      int sStart = startCount;
      int bStart = bulkCount;
      issueCmd(2'b10);
      finishCompute(delay, earlyDone, sStart, bStart);
   endtask

   // Drains all 18 registers; stallMode holds ready low for 3 cycles when index 4 is offered.
   task automatic doRead(input bit stallMode, input bit randomReady);
      int n = 0;
      int cycles = 0;
      int stalls = 0;
      bit stalling;
      issueCmd(2'b11);
      for (int i = 0; i < NREGS; i++) readQ.push_back({5'(i), refMem[i]});
      while (n < NREGS && cycles < 300) begin
         stalling = stallMode && n == 4 && stalls < 3;
         if (stalling) begin
            result_ready_in = 1'b0;
            stalls++;
         end else begin
            result_ready_in = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clock_in);
         if (stalling) begin
            checkOutput("stall valid", {31'b0, result_valid_out}, 32'd1);
            checkOutput("stall addr", {27'b0, rdAddr}, 32'd4);
            checkOutput("stall data", {24'b0, result_data_out}, {24'b0, refMem[4]});
         end
         if (result_valid_out && result_ready_in) n++;
         tick();
         cycles++;
      end
      result_ready_in = 1'b0;
      checkOutput("read transfers", n, 32'd18);
      checkOutput("read idle", {31'b0, cmd_ready_out}, 32'd1);
      checkOutput("read queue drained", readQ.size(), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " cmd_ready"}, {31'b0, cmd_ready_out}, 32'd1);
      checkOutput({tag, " busy"}, {31'b0, busy_out}, 32'd0);
      checkOutput({tag, " load_ready"}, {31'b0, load_data_ready_out}, 32'd0);
      checkOutput({tag, " outputs"}, {26'b0, nbWe, bulkWe, tc_start_out, result_valid_out, 2'b0}, 32'd0);
      checkOutput({tag, " counter"}, {27'b0, rdAddr}, 32'd0);
`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
      checkOutput({tag, " error"}, {31'b0, error_out}, 32'd0);
`endif
   endtask

`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
   task automatic doTimeout();
      int sStart;
      int bStart = bulkCount;
      issueCmd(2'b10);
      tick();
      repeat (TO_CYCLES - 1) tick();
      checkOutput("pre-timeout busy", {31'b0, busy_out}, 32'd1);
      checkOutput("pre-timeout error", {31'b0, error_out}, 32'd0);
      tick();
      checkOutput("timeout idle", {31'b0, cmd_ready_out}, 32'd1);
      checkOutput("timeout error", {31'b0, error_out}, 32'd1);
      checkOutput("timeout no bulk", bulkCount - bStart, 32'd0);
      repeat (2) tick();
      checkOutput("error sticky", {31'b0, error_out}, 32'd1);
      sStart = startCount;
      bStart = bulkCount;
      issueCmd(2'b10);
      checkOutput("error cleared", {31'b0, error_out}, 32'd0);
      finishCompute(3, 1'b0, sStart, bStart);
   endtask
`endif

   task automatic applyStimulus();
      for (int i = 0; i < NREGS; i++) begin
         rfMem[i] = 8'h00;
         refMem[i] = 8'h00;
         tcResult[i] = 8'h00;
      end
      reset_in = 1'b1;
      tick();
      tick();
      checkResetState("reset");
      reset_in = 1'b0;
      tick();

      issueCmd(2'b00);
      checkOutput("nop stays idle", {31'b0, busy_out}, 32'd0);

      doLoad(0, NREGS);
      doRead(1'b1, 1'b0);
      doCompute(5, 1'b1);
      doRead(1'b0, 1'b1);
      doLoad(1, NREGS);
      doRead(1'b0, 1'b0);

      doLoad(2, 7);
      reset_in = 1'b1;
      tick();
      checkResetState("mid-load reset");
      reset_in = 1'b0;
      load_data_valid_in = 1'b1;
      load_data_in = 8'h55;
      repeat (3) tick();
      load_data_valid_in = 1'b0;
      checkOutput("idle ignores load bytes", {31'b0, busy_out}, 32'd0);
      doLoad(2, NREGS);
      doRead(1'b0, 1'b1);

`ifdef TENSOR_CORE_CONTROLLER_TIMEOUT_EN
      doTimeout();
      doRead(1'b0, 1'b0);
`endif

      for (int r = 0; r < 8; r++) begin
         case ($urandom_range(0, 2))
            0: doLoad(2, NREGS);
            1: doCompute($urandom_range(0, 6), 1'($urandom_range(0, 1)));
            default: doRead(1'b0, 1'b1);
         endcase
      end
      doRead(1'b0, 1'b0);
   endtask

   initial begin
      applyStimulus();
      repeat (2) tick();
      checkOutput("final write queue", writeQ.size(), 32'd0);
      checkOutput("final read queue", readQ.size(), 32'd0);
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global time limit: actual=expired required=finished");
      $fatal(1, "[TB] time limit");
   end

endmodule
